// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer: parallel word in, serial bit stream out.
interface word_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] I;
  logic             I_valid;
  logic             I_ready;
  logic             O;
  logic             O_valid;
  logic             O_ready;
  logic             O_last;
  logic             O_and;

  // Valid/ready on both sides: a beat moves on a rising edge where valid && ready.
  // Once valid is raised, payload stays stable until ready takes it; I_ready may
  // depend combinationally on O_ready (last-beat reload path).
  modport slave (
    input  I, I_valid, O_ready,
    output I_ready, O, O_valid, O_last, O_and
  );

  modport master (
    output I, I_valid, O_ready,
    input  I_ready, O, O_valid, O_last, O_and
  );
endinterface

// File: rtl/word_serializer.sv
// LSB-first word serializer with a running AND-reduction of the bits sent so far.
module word_serializer #(
  parameter int WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  word_serializer_if.slave    bus,
  output logic                busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             acc_q,   acc_d;

  logic in_shift;
  logic is_last;
  logic o_and;
  logic i_ready;
  logic in_xfer;
  logic out_xfer;

  assign in_shift = (state_q == ST_SHIFT);
  assign is_last  = in_shift && (cnt_q == CNT_LAST);
  assign o_and    = in_shift && acc_q && shreg_q[0];

  // Accept a new word when idle, or on the cycle the last beat is consumed.
  assign i_ready  = !RESET && ((state_q == ST_IDLE) || (is_last && bus.O_ready));
  assign in_xfer  = bus.I_valid && i_ready;
  assign out_xfer = in_shift && bus.O_ready;

  assign bus.I_ready = i_ready;
  assign bus.O_valid = in_shift;
  assign bus.O       = in_shift && shreg_q[0];
  assign bus.O_last  = is_last;
  assign bus.O_and   = o_and;
  assign busy        = in_shift;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          shreg_d = bus.I;
          cnt_d   = '0;
          acc_d   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (out_xfer) begin
          if (is_last) begin
            if (in_xfer) begin
              shreg_d = bus.I;
              cnt_d   = '0;
              acc_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              acc_d   = 1'b1;
            end
          end else begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            acc_d   = o_and;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (WIDTH=4) with hand-computed expected beats.
module tb_word_serializer;

  localparam int WIDTH = 4;

  logic CLK;
  logic RESET;
  logic busy;

  int n_cmp;
  int n_bad;

  word_serializer_if #(.WIDTH(WIDTH)) bus ();

  word_serializer #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .busy  (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one presented beat, then advance a clock.
  task automatic beat(input string tag, input logic e_o, input logic e_and, input logic e_last);
    chk({tag, ".valid"}, 32'(bus.O_valid), 32'd1);
    chk({tag, ".o"},     32'(bus.O),       32'(e_o));
    chk({tag, ".and"},   32'(bus.O_and),   32'(e_and));
    chk({tag, ".last"},  32'(bus.O_last),  32'(e_last));
    step();
  endtask

  task automatic load(input logic [WIDTH-1:0] w, input string tag);
    bus.I       = w;
    bus.I_valid = 1'b1;
    chk({tag, ".i_ready"}, 32'(bus.I_ready), 32'd1);
    step();
    bus.I_valid = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".o_valid"}, 32'(bus.O_valid), 32'd0);
    chk({tag, ".i_ready"}, 32'(bus.I_ready), 32'd1);
    chk({tag, ".busy"},    32'(busy),        32'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    RESET       = 1'b1;
    bus.I       = '0;
    bus.I_valid = 1'b0;
    bus.O_ready = 1'b1;
    step();
    step();
    chk("rst.i_ready", 32'(bus.I_ready), 32'd0);
    chk("rst.o_valid", 32'(bus.O_valid), 32'd0);
    RESET = 1'b0;
    #1;
    idle_chk("post_rst");
    chk("post_rst.o",    32'(bus.O),      32'd0);
    chk("post_rst.last", 32'(bus.O_last), 32'd0);
    chk("post_rst.and",  32'(bus.O_and),  32'd0);

    // 1011 with O_ready held high
    load(4'b1011, "w1011");
    beat("w1011.b1", 1'b1, 1'b1, 1'b0);
    beat("w1011.b2", 1'b1, 1'b1, 1'b0);
    beat("w1011.b3", 1'b0, 1'b0, 1'b0);
    beat("w1011.b4", 1'b1, 1'b0, 1'b1);
    idle_chk("w1011.end");

    // All ones keeps the AND chain high through the last beat
    load(4'b1111, "w1111");
    beat("w1111.b1", 1'b1, 1'b1, 1'b0);
    beat("w1111.b2", 1'b1, 1'b1, 1'b0);
    beat("w1111.b3", 1'b1, 1'b1, 1'b0);
    beat("w1111.b4", 1'b1, 1'b1, 1'b1);
    idle_chk("w1111.end");

    // 0110 with a three-cycle stall on beat 2
    load(4'b0110, "w0110");
    beat("w0110.b1", 1'b0, 1'b0, 1'b0);
    bus.O_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("w0110.stall.i_ready", 32'(bus.I_ready), 32'd0);
      beat("w0110.stall", 1'b1, 1'b0, 1'b0);
    end
    bus.O_ready = 1'b1;
    beat("w0110.b2", 1'b1, 1'b0, 1'b0);
    beat("w0110.b3", 1'b1, 1'b0, 1'b0);
    beat("w0110.b4", 1'b0, 1'b0, 1'b1);
    idle_chk("w0110.end");

    // Back-to-back 0001 then 1110 with I_valid held
    load(4'b0001, "b2b1");
    bus.I       = 4'b1110;
    bus.I_valid = 1'b1;
    chk("b2b.b1.i_ready", 32'(bus.I_ready), 32'd0);
    beat("b2b1.b1", 1'b1, 1'b1, 1'b0);
    chk("b2b.b2.i_ready", 32'(bus.I_ready), 32'd0);
    beat("b2b1.b2", 1'b0, 1'b0, 1'b0);
    chk("b2b.b3.i_ready", 32'(bus.I_ready), 32'd0);
    beat("b2b1.b3", 1'b0, 1'b0, 1'b0);
    chk("b2b.b4.i_ready", 32'(bus.I_ready), 32'd1);
    beat("b2b1.b4", 1'b0, 1'b0, 1'b1);
    bus.I_valid = 1'b0;
    beat("b2b2.b1", 1'b0, 1'b0, 1'b0);
    beat("b2b2.b2", 1'b1, 1'b0, 1'b0);
    beat("b2b2.b3", 1'b1, 1'b0, 1'b0);
    beat("b2b2.b4", 1'b1, 1'b0, 1'b1);
    idle_chk("b2b.end");

    // Reset after beat 2 of 1101 discards the word
    load(4'b1101, "w1101");
    beat("w1101.b1", 1'b1, 1'b1, 1'b0);
    beat("w1101.b2", 1'b0, 1'b0, 1'b0);
    RESET = 1'b1;
    #1;
    chk("mid_rst.i_ready", 32'(bus.I_ready), 32'd0);
    step();
    RESET = 1'b0;
    #1;
    idle_chk("mid_rst.after");
    step();
    idle_chk("mid_rst.after2");
    load(4'b0101, "w0101");
    beat("w0101.b1", 1'b1, 1'b1, 1'b0);
    beat("w0101.b2", 1'b0, 1'b0, 1'b0);
    beat("w0101.b3", 1'b1, 1'b0, 1'b0);
    beat("w0101.b4", 1'b0, 1'b0, 1'b1);
    idle_chk("w0101.end");

    // I_valid toggled during beats 1-3 must not disturb the word in flight
    load(4'b1001, "w1001");
    bus.I = 4'b0110;
    bus.I_valid = 1'b1;
    chk("tog.b1.i_ready", 32'(bus.I_ready), 32'd0);
    beat("w1001.b1", 1'b1, 1'b1, 1'b0);
    bus.I_valid = 1'b0;
    chk("tog.b2.i_ready", 32'(bus.I_ready), 32'd0);
    beat("w1001.b2", 1'b0, 1'b0, 1'b0);
    bus.I_valid = 1'b1;
    chk("tog.b3.i_ready", 32'(bus.I_ready), 32'd0);
    beat("w1001.b3", 1'b0, 1'b0, 1'b0);
    bus.I_valid = 1'b0;
    beat("w1001.b4", 1'b1, 1'b0, 1'b1);
    idle_chk("w1001.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Accepts a packed WIDTH-bit word over a valid/ready input handshake.
- Emits the word one bit per beat, LSB first, over a valid/ready output handshake, marking the final beat.
- Alongside each bit, emits the running AND-reduction of all bits sent so far in the current word.
- Serves as the parallel-to-serial counterpart of our packed AND-chain datapaths. It feeds bit-serial consumers and terminators that need the chain result incrementally.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- I  input  WIDTH  packed input word; bit 0 is sent first.
- I_valid  input  1  input word is present.
- I_ready  output  1  block accepts I this cycle.
- O  output  1  current serial bit.
- O_valid  output  1  O, O_last and O_and are valid.
- O_ready  input  1  downstream consumes the current beat.
- O_last  output  1  current beat carries bit WIDTH-1.
- O_and  output  1  AND of bits 0..current of the current word.
- busy  output  1  a word is held (state SHIFT).

Behaviour:
- Handshake rules:
  - Input transfer occurs when I_valid && I_ready are high at a rising edge.
  - Output transfer occurs when O_valid && O_ready are high at a rising edge.
- State register holds shreg[WIDTH-1:0], cnt[$clog2(WIDTH)-1:0], acc (1 bit) and state ∈ {IDLE, SHIFT}.
- Reset:
  - RESET high at an edge sets state=IDLE, shreg=0, cnt=0, acc=1.
  - While RESET is high, I_ready=0 combinationally.
  - After reset, every output is 0.
- IDLE:
  - I_ready=1; O_valid=0; O, O_last, O_and forced to 0; busy=0.
  - An input transfer loads shreg<=I, cnt<=0, acc<=1 and moves to SHIFT.
- SHIFT:
  - O_valid=1; O=shreg[0]; O_last=(cnt==WIDTH-1); O_and=acc & shreg[0]; busy=1.
  - On an output transfer that is not the last beat: shreg<=shreg>>1, cnt<=cnt+1, acc<=O_and.
  - On an output transfer that is the last beat:
    - If I_valid is high, load the next word as in IDLE and stay in SHIFT. This gives zero-bubble back-to-back words.
    - Otherwise go to IDLE.
  - With O_ready low, all state and outputs hold. O and O_valid must stay stable until the beat is taken.
- I_ready timing:
  - I_ready = !RESET && (state==IDLE || (O_last && O_ready)).
  - This is a combinational path from O_ready to I_ready, documented and allowed.
  - An input offered while in SHIFT but not on a consumed last beat is not accepted. The source must hold it.
- Latency and throughput:
  - The first bit appears the cycle after the input transfer; O has no combinational path from I.
  - Sustained throughput is exactly one word per WIDTH cycles when O_ready=1.
- O_and resets to 1 at every word load. It never carries over between words.
- Reset mid-word:
  - The word is discarded. O_valid=0 from the cycle after the reset edge.
  - No partial beats are replayed.
- cnt never exceeds WIDTH-1. It wraps only through reload or the return to IDLE.

Test Plan:
- WIDTH=4, O_ready=1, accept I=4'b1011 → next 4 cycles: O=1,1,0,1; O_and=1,1,0,0; O_last only on beat 4; then O_valid=0, I_ready=1.
- I=4'b1111 → O_and=1,1,1,1; O_last with O_and=1 on beat 4.
- I=4'b0110, O_ready low for 3 cycles starting at beat 2 → O=1, O_and=0 held for 3 cycles; word completes in 7 cycles; no bit is lost or duplicated.
- I_valid held with 4'b0001 then 4'b1110 → 8 consecutive O_valid cycles with O=1,0,0,0,0,1,1,1; I_ready high only in IDLE and on beat 4 of word 1; O_and for word 2 = 0,0,0,0.
- RESET pulsed after beat 2 of 4'b1101 → O_valid=0 the next cycle; I_ready=0 during RESET, then 1. Next word 4'b0101 → O=1,0,1,0 and O_and=1,0,0,0.
- I_valid toggled during beats 1–3 with O_ready=1 → I_ready=0 on those beats and no load occurs; the word in flight emits unaltered.
